turn_signal_sequencer: RTL and testbench



---
 rtl/turn_signal_pkg.sv | 25 ++
 rtl/turn_signal_prescaler.sv | 35 +++
 rtl/turn_signal_sequencer.sv | 142 ++++++++++++++
 tb/tb_turn_signal_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/turn_signal_pkg.sv
// Shared types and helpers for the tail-light turn-signal sequencer.
// Optional brake overlay is selected by TURN_SIGNAL_BRAKE_EN.
package turn_signal_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT,
        HAZ
    } mode_e;

    localparam int DEF_LAMPS    = 3;
    localparam int DEF_TICK_DIV = 1;
    localparam int MAX_LAMPS    = 64;

    // Low n bits set; callers narrow the result to their lamp width.
    function automatic logic [MAX_LAMPS-1:0] thermo(input int unsigned n);
        logic [MAX_LAMPS-1:0] t;
        for (int unsigned i = 0; i < MAX_LAMPS; i++) begin
            t[i] = (i < n);
        end
        return t;
    endfunction

endpackage

// File: rtl/turn_signal_prescaler.sv
// Step prescaler: counts 0..TICK_DIV-1 and flags the last count as a tick.
// clear holds/reloads the count at zero.
module turn_signal_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = (count_q == LAST);

    always_comb begin
        count_d = count_q + CW'(1);
        if (clear || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/turn_signal_sequencer.sv
// Tail-light sequencer: left/right thermometer sweep and hazard flash.
// Define TURN_SIGNAL_BRAKE_EN to add the brake_sw overlay input.
module turn_signal_sequencer
    import turn_signal_pkg::*;
#(
    parameter int LAMPS    = DEF_LAMPS,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic             clk,
    input  logic             reset,
`ifdef TURN_SIGNAL_BRAKE_EN
    input  logic             brake_sw,
`endif
    input  logic             left_sw,
    input  logic             right_sw,
    input  logic             hazard_sw,
    output logic [LAMPS-1:0] l_lamps,
    output logic [LAMPS-1:0] r_lamps,
    output logic             busy
);

    localparam int SW = $clog2(LAMPS + 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(LAMPS);
    localparam logic [LAMPS-1:0] ALL_ON = '1;

    mode_e            state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic             haz_on_q, haz_on_d;
    logic [LAMPS-1:0] l_lamps_q, l_lamps_d;
    logic [LAMPS-1:0] r_lamps_q, r_lamps_d;
    logic [SW-1:0]    next_step;
    logic             haz_req;
    logic             clear;
    logic             tick;
    logic             brake;

`ifdef TURN_SIGNAL_BRAKE_EN
    assign brake = brake_sw;
`else
    assign brake = 1'b0;
`endif

    turn_signal_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .tick  (tick)
    );

    assign haz_req   = hazard_sw | (left_sw & right_sw);
    assign next_step = (step_q == LAST_STEP) ? '0 : step_q + SW'(1);
    assign clear     = (state_q == IDLE) || (state_d != state_q);

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        haz_on_d = haz_on_q;
        unique case (state_q)
            IDLE: begin
                if (haz_req) begin
                    state_d  = HAZ;
                    haz_on_d = 1'b1;
                end else if (left_sw) begin
                    state_d = LEFT;
                    step_d  = SW'(1);
                end else if (right_sw) begin
                    state_d = RIGHT;
                    step_d  = SW'(1);
                end
            end
            LEFT, RIGHT: begin
                if (haz_req) begin
                    state_d  = HAZ;
                    step_d   = '0;
                    haz_on_d = 1'b1;
                end else if ((state_q == LEFT) ? !left_sw : !right_sw) begin
                    state_d = IDLE;
                    step_d  = '0;
                end else if (tick) begin
                    step_d = next_step;
                end
            end
            HAZ: begin
                if (!haz_req) begin
                    state_d  = IDLE;
                    haz_on_d = 1'b0;
                end else if (tick) begin
                    haz_on_d = !haz_on_q;
                end
            end
        endcase
    end

    // Lamps follow the next state so they change on the same edge.
    always_comb begin
        l_lamps_d = '0;
        r_lamps_d = '0;
        case (state_d)
            IDLE: begin
                if (brake) begin
                    l_lamps_d = ALL_ON;
                    r_lamps_d = ALL_ON;
                end
            end
            LEFT: begin
                l_lamps_d = LAMPS'(thermo(32'(step_d)));
                if (brake) r_lamps_d = ALL_ON;
            end
            RIGHT: begin
                r_lamps_d = LAMPS'(thermo(32'(step_d)));
                if (brake) l_lamps_d = ALL_ON;
            end
            default: begin
                l_lamps_d = {LAMPS{haz_on_d}};
                r_lamps_d = {LAMPS{haz_on_d}};
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            step_q    <= '0;
            haz_on_q  <= 1'b0;
            l_lamps_q <= '0;
            r_lamps_q <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            haz_on_q  <= haz_on_d;
            l_lamps_q <= l_lamps_d;
            r_lamps_q <= r_lamps_d;
        end
    end

    assign l_lamps = l_lamps_q;
    assign r_lamps = r_lamps_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_turn_signal_sequencer.sv
// Bench for turn_signal_sequencer: three configurations against a
// mode/elapsed-time reference model, directed steps then random switches.
module tb_turn_signal_sequencer;

    localparam int M_IDLE = 0;
    localparam int M_LEFT = 1;
    localparam int M_RGHT = 2;
    localparam int M_HAZ  = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic left_sw = 1'b0;
    logic right_sw = 1'b0;
    logic hazard_sw = 1'b0;
    logic brake_sw = 1'b0;

    logic [2:0] l0, r0, l1, r1;
    logic       l2, r2;
    logic [2:0] busy;

    int tests = 0;
    int fails = 0;

    int nl[3] = '{3, 3, 1};
    int dv[3] = '{2, 1, 3};
    int mode[3];
    int el[3];

    always #5 clk = ~clk;

    turn_signal_sequencer #(.LAMPS(3), .TICK_DIV(2)) dut0 (
        .clk(clk), .reset(reset),
`ifdef TURN_SIGNAL_BRAKE_EN
        .brake_sw(brake_sw),
`endif
        .left_sw(left_sw), .right_sw(right_sw), .hazard_sw(hazard_sw),
        .l_lamps(l0), .r_lamps(r0), .busy(busy[0])
    );

    turn_signal_sequencer #(.LAMPS(3), .TICK_DIV(1)) dut1 (
        .clk(clk), .reset(reset),
`ifdef TURN_SIGNAL_BRAKE_EN
        .brake_sw(brake_sw),
`endif
        .left_sw(left_sw), .right_sw(right_sw), .hazard_sw(hazard_sw),
        .l_lamps(l1), .r_lamps(r1), .busy(busy[1])
    );

    turn_signal_sequencer #(.LAMPS(1), .TICK_DIV(3)) dut2 (
        .clk(clk), .reset(reset),
`ifdef TURN_SIGNAL_BRAKE_EN
        .brake_sw(brake_sw),
`endif
        .left_sw(left_sw), .right_sw(right_sw), .hazard_sw(hazard_sw),
        .l_lamps(l2), .r_lamps(r2), .busy(busy[2])
    );

    function automatic logic [7:0] obs_l(int k);
        return (k == 0) ? {5'b0, l0} : (k == 1) ? {5'b0, l1} : {7'b0, l2};
    endfunction

    function automatic logic [7:0] obs_r(int k);
        return (k == 0) ? {5'b0, r0} : (k == 1) ? {5'b0, r1} : {7'b0, r2};
    endfunction

    function automatic logic [7:0] ones(int n);
        return 8'((1 << n) - 1);
    endfunction

    function automatic logic brake_on();
`ifdef TURN_SIGNAL_BRAKE_EN
        return brake_sw;
`else
        return 1'b0;
`endif
    endfunction

    // Sweep position: entry shows one lamp, one more per elapsed step,
    // wrapping through all-off every LAMPS+1 steps.
    function automatic logic [7:0] sweep(int k);
        return ones((1 + el[k] / dv[k]) % (nl[k] + 1));
    endfunction

    function automatic logic [7:0] exp_l(int k);
        case (mode[k])
            M_LEFT:  return sweep(k);
            M_RGHT:  return brake_on() ? ones(nl[k]) : 8'h0;
            M_HAZ:   return ((el[k] / dv[k]) % 2 == 0) ? ones(nl[k]) : 8'h0;
            default: return brake_on() ? ones(nl[k]) : 8'h0;
        endcase
    endfunction

    function automatic logic [7:0] exp_r(int k);
        case (mode[k])
            M_RGHT:  return sweep(k);
            M_LEFT:  return brake_on() ? ones(nl[k]) : 8'h0;
            M_HAZ:   return ((el[k] / dv[k]) % 2 == 0) ? ones(nl[k]) : 8'h0;
            default: return brake_on() ? ones(nl[k]) : 8'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mode[k] = M_IDLE;
            el[k]   = 0;
        end
    endtask

    task automatic model_edge();
        logic hz;
        hz = hazard_sw | (left_sw & right_sw);
        for (int k = 0; k < 3; k++) begin
            case (mode[k])
                M_IDLE: begin
                    el[k] = 0;
                    if (hz)            mode[k] = M_HAZ;
                    else if (left_sw)  mode[k] = M_LEFT;
                    else if (right_sw) mode[k] = M_RGHT;
                end
                M_LEFT, M_RGHT: begin
                    if (hz) begin
                        mode[k] = M_HAZ;
                        el[k]   = 0;
                    end else if (mode[k] == M_LEFT ? !left_sw : !right_sw) begin
                        mode[k] = M_IDLE;
                        el[k]   = 0;
                    end else begin
                        el[k]++;
                    end
                end
                default: begin
                    if (!hz) begin
                        mode[k] = M_IDLE;
                        el[k]   = 0;
                    end else begin
                        el[k]++;
                    end
                end
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, o, e, $time);
        end
    endtask

    task automatic chk_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("cfg%0d_l", k), obs_l(k), exp_l(k));
            chk($sformatf("cfg%0d_r", k), obs_r(k), exp_r(k));
            chk($sformatf("cfg%0d_busy", k), {7'b0, busy[k]},
                {7'b0, mode[k] != M_IDLE});
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            chk_all();
        end
    endtask

    initial begin
        model_reset();
        #1;
        chk_all();
        chk("reset_l0", {5'b0, l0}, 8'h00);
        #1 reset = 1'b0;
        cyc(2);

        // left held, TICK_DIV=2
        left_sw = 1'b1;
        cyc(1); chk("tp1_001", {5'b0, l0}, 8'h01);
        cyc(2); chk("tp1_011", {5'b0, l0}, 8'h03);
        cyc(2); chk("tp1_111", {5'b0, l0}, 8'h07);
        cyc(2); chk("tp1_000", {5'b0, l0}, 8'h00);
        cyc(2); chk("tp1_wrap", {5'b0, l0}, 8'h01);
        chk("tp1_r", {5'b0, r0}, 8'h00);
        chk("tp1_busy", {7'b0, busy[0]}, 8'h01);

        // hazard interrupts left at 011
        cyc(2); chk("tp3_pre", {5'b0, l0}, 8'h03);
        hazard_sw = 1'b1;
        cyc(1); chk("tp3_on", {2'b0, l0, r0}, 8'h3f);
        cyc(2); chk("tp3_off", {2'b0, l0, r0}, 8'h00);
        hazard_sw = 1'b0;
        left_sw   = 1'b0;
        cyc(2);

        // right pulse, TICK_DIV=1
        right_sw = 1'b1;
        cyc(1); chk("tp2_001", {5'b0, r1}, 8'h01);
        cyc(1); chk("tp2_011", {5'b0, r1}, 8'h03);
        right_sw = 1'b0;
        cyc(1); chk("tp2_off", {5'b0, r1}, 8'h00);
        chk("tp2_busy", {7'b0, busy[1]}, 8'h00);

        // both switches give hazard; dropping one passes through IDLE
        left_sw  = 1'b1;
        right_sw = 1'b1;
        cyc(1); chk("tp4_haz", {2'b0, l0, r0}, 8'h3f);
        right_sw = 1'b0;
        cyc(1); chk("tp4_idle", {5'b0, busy}, 8'h00);
        cyc(1); chk("tp4_left", {5'b0, l0}, 8'h01);
        left_sw = 1'b0;
        cyc(2);

        // asynchronous reset mid-hazard
        hazard_sw = 1'b1;
        cyc(1); chk("tp5_on", {5'b0, l0}, 8'h07);
        reset = 1'b1;
        #1;
        model_reset();
        chk_all();
        chk("tp5_async", {2'b0, l0, r0}, 8'h00);
        hazard_sw = 1'b0;
        reset     = 1'b0;
        cyc(3);

`ifdef TURN_SIGNAL_BRAKE_EN
        left_sw  = 1'b1;
        brake_sw = 1'b1;
        cyc(3); chk("brk_r", {5'b0, r0}, 8'h07);
        hazard_sw = 1'b1;
        cyc(3);
        hazard_sw = 1'b0;
        left_sw   = 1'b0;
        brake_sw  = 1'b0;
        cyc(2);
`endif

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) left_sw   = ~left_sw;
            if ($urandom_range(7) == 0) right_sw  = ~right_sw;
            if ($urandom_range(15) == 0) hazard_sw = ~hazard_sw;
`ifdef TURN_SIGNAL_BRAKE_EN
            if ($urandom_range(9) == 0) brake_sw = ~brake_sw;
`endif
            if ($urandom_range(499) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                chk_all();
                reset = 1'b0;
            end
            cyc(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
